// File: rtl/etc_pkg.sv
// Shared opcodes, tile type and sizing helpers for the extended-tensor-core tile issuer.
package etc_pkg;

  localparam logic [1:0] OP_MAC = 2'd0;
  localparam logic [1:0] OP_L2D = 2'd1;

  typedef logic [3:0][3:0][15:0] tile16_t;

  // Width able to hold every value 0..depth of an occupancy counter.
  function automatic int unsigned fifoCountW(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/etc_result_fifo.sv
// Synchronous result FIFO with a registered head entry, occupancy count and full/empty flags.
module etc_result_fifo
  import etc_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned EW    = 8,
  parameter int unsigned CNTW  = fifoCountW(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic [EW-1:0]   pushData,
  input  logic            pop,
  output logic            full,
  output logic            empty,
  output logic [CNTW-1:0] count,
  output logic [EW-1:0]   head
);

  localparam int unsigned PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [EW-1:0]   mem [DEPTH];
  logic [PTRW-1:0] wrPtr;
  logic [PTRW-1:0] rdPtr;
  logic [PTRW-1:0] rdPtrNext;
  logic [CNTW-1:0] countQ;
  logic [EW-1:0]   headQ;
  logic            doPush;
  logic            doPop;

  // Pointer increment that wraps at DEPTH, so non-power-of-two depths also work.
  function automatic logic [PTRW-1:0] ptrInc(input logic [PTRW-1:0] p);
    return (p == PTRW'(DEPTH - 1)) ? '0 : p + PTRW'(1);
  endfunction

  assign full      = (countQ == CNTW'(DEPTH));
  assign empty     = (countQ == '0);
  assign count     = countQ;
  assign head      = headQ;
  assign doPop     = pop & ~empty;
  assign doPush    = push & ~full;
  assign rdPtrNext = ptrInc(rdPtr);

  // Storage array; no reset needed since reads are gated by the count.
  always_ff @(posedge clk) begin
    if (doPush) begin
      mem[wrPtr] <= pushData;
    end
  end

  // Pointers and occupancy; a simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr  <= '0;
      rdPtr  <= '0;
      countQ <= '0;
    end else begin
      if (doPush) begin
        wrPtr <= ptrInc(wrPtr);
      end
      if (doPop) begin
        rdPtr <= rdPtrNext;
      end
      case ({doPush, doPop})
        2'b10:   countQ <= countQ + CNTW'(1);
        2'b01:   countQ <= countQ - CNTW'(1);
        default: countQ <= countQ;
      endcase
    end
  end

  // Head register tracks the oldest entry; it reads zero whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      headQ <= '0;
    end else if (doPop) begin
      if (countQ > CNTW'(1)) begin
        headQ <= mem[rdPtrNext];
      end else if (doPush) begin
        headQ <= pushData;
      end else begin
        headQ <= '0;
      end
    end else if (doPush && empty) begin
      headQ <= pushData;
    end
  end

  // The caller's credit scheme must never offer an entry to a full FIFO.
  assert property (@(posedge clk) disable iff (rst) !(push && full));

endmodule

// File: rtl/etc_tile_issuer.sv
// Issues tile operations to a fixed-latency tensor core and returns results in order under credit.
module etc_tile_issuer
  import etc_pkg::*;
#(
  parameter int unsigned W     = 16,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAGW  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [1:0]                 req_op,
  input  logic [3:0][3:0][W-1:0]     req_a,
  input  logic [3:0][3:0][W-1:0]     req_b,
  input  logic [TAGW-1:0]            req_tag,
  output logic [3:0][3:0][W-1:0]     core_inA,
  output logic [3:0][3:0][W-1:0]     core_inB,
  output logic [1:0]                 core_op,
  input  logic [3:0][3:0][W-1:0]     core_out,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [3:0][3:0][W-1:0]     res_data,
  output logic [TAGW-1:0]            res_tag,
  output logic [1:0]                 res_op,
  output logic                       busy
);

  localparam int unsigned CNTW  = fifoCountW(DEPTH);
  localparam int unsigned SUMW  = CNTW + 1;
  localparam int unsigned TILEW = 16 * W;
  localparam int unsigned EW    = TILEW + TAGW + 2;

  typedef struct packed {
    logic            valid;
    logic [TAGW-1:0] tag;
    logic [1:0]      op;
  } stage_t;

  stage_t          s1Q;
  stage_t          s2Q;
  logic            fire;
  logic            readyInt;
  logic [SUMW-1:0] creditSum;
  logic            fifoFull;
  logic            fifoEmpty;
  logic [CNTW-1:0] fifoCount;
  logic [EW-1:0]   fifoHead;
  logic [EW-1:0]   fifoPushData;
  logic            fifoPop;
  logic            resValidInt;

  // Credit: everything in flight plus everything queued must fit in the FIFO.
  assign creditSum = SUMW'(fifoCount) + SUMW'(s1Q.valid) + SUMW'(s2Q.valid);
  assign readyInt  = ~rst & (creditSum < SUMW'(DEPTH));
  assign req_ready = readyInt;
  assign fire      = req_valid & readyInt;

  // Operands go to the core in the accept cycle; op follows one cycle later.
  assign core_inA = fire ? req_a : '0;
  assign core_inB = fire ? req_b : '0;
  assign core_op  = (~rst & s1Q.valid) ? s1Q.op : OP_MAC;

  // Two-stage tracker mirroring the core's operand and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1Q <= '0;
      s2Q <= '0;
    end else begin
      s1Q <= fire ? stage_t'{valid: 1'b1, tag: req_tag, op: req_op} : '0;
      s2Q <= s1Q;
    end
  end

  assign fifoPushData = {core_out, s2Q.tag, s2Q.op};
  assign resValidInt  = ~rst & ~fifoEmpty;
  assign fifoPop      = resValidInt & res_ready;

  etc_result_fifo #(
    .DEPTH (DEPTH),
    .EW    (EW)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (s2Q.valid),
    .pushData (fifoPushData),
    .pop      (fifoPop),
    .full     (fifoFull),
    .empty    (fifoEmpty),
    .count    (fifoCount),
    .head     (fifoHead)
  );

  assign res_valid = resValidInt;
  assign res_data  = rst ? '0 : fifoHead[EW-1 -: TILEW];
  assign res_tag   = rst ? '0 : fifoHead[TAGW+1 -: TAGW];
  assign res_op    = rst ? '0 : fifoHead[1:0];
  assign busy      = ~rst & (s1Q.valid | s2Q.valid | ~fifoEmpty);

  // A result arriving from the core must always find a free FIFO slot.
  assert property (@(posedge clk) disable iff (rst) !(s2Q.valid && fifoFull));

endmodule

// File: tb/tb_etc_tile_issuer.sv
// Scoreboard bench for etc_tile_issuer with a behavioural tensor-core model.
module tb_etc_tile_issuer;
  import etc_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_op;
  tile16_t    req_a;
  tile16_t    req_b;
  logic [3:0] req_tag;
  tile16_t    core_inA;
  tile16_t    core_inB;
  logic [1:0] core_op;
  tile16_t    core_out;
  logic       res_valid;
  logic       res_ready;
  tile16_t    res_data;
  logic [3:0] res_tag;
  logic [1:0] res_op;
  logic       busy;

  typedef struct {
    tile16_t    data;
    logic [3:0] tag;
    logic [1:0] op;
  } exp_t;

  exp_t    expQ[$];
  int      total = 0;
  int      bad = 0;
  int      outstanding = 0;
  int      maxOut = 0;
  int      popCount = 0;
  tile16_t coreRegA;
  tile16_t coreRegB;
  tile16_t coreOutQ;
  tile16_t zeroT;

  etc_tile_issuer #(.W(16), .DEPTH(4), .TAGW(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
    .core_inA(core_inA), .core_inB(core_inB), .core_op(core_op), .core_out(core_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_tag(res_tag), .res_op(res_op), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference tensor core: MAC is C=A*B, L2 is sum over k of (A[i][k]-B[j][k])^2, all mod 2^16.
  function automatic tile16_t coreModel(input logic [1:0] op, input tile16_t a, input tile16_t b);
    tile16_t r;
    logic [15:0] acc;
    logic [15:0] d;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        acc = 16'd0;
        for (int k = 0; k < 4; k++) begin
          if (op == OP_MAC) begin
            acc = 16'(acc + 16'(a[i][k] * b[k][j]));
          end else begin
            d   = 16'(a[i][k] - b[j][k]);
            acc = 16'(acc + 16'(d * d));
          end
        end
        r[i][j] = acc;
      end
    end
    return r;
  endfunction

  // Core timing: operands registered at edge N, output register samples op at edge N+1.
  always @(posedge clk) begin
    coreRegA <= core_inA;
    coreRegB <= core_inB;
    coreOutQ <= coreModel(core_op, coreRegA, coreRegB);
  end
  assign core_out = coreOutQ;

  function automatic tile16_t mkTile(input int seed);
    tile16_t t;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        t[i][j] = 16'(seed * 7 + i * 5 + j * 3 + 1);
      end
    end
    return t;
  endfunction

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic checkTile(input string name, input tile16_t act, input tile16_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic setReq(input logic v, input logic [1:0] op, input tile16_t a, input tile16_t b,
                        input logic [3:0] tag);
    req_valid = v;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    req_tag   = tag;
  endtask

  // Called at the negedge: records an accept that will happen at the coming edge.
  task automatic sampleFire(output logic fired);
    fired = req_valid && req_ready;
    if (fired) begin
      expQ.push_back('{data: coreModel(req_op, req_a, req_b), tag: req_tag, op: req_op});
      outstanding++;
    end
  endtask

  task automatic drain(input string name, input logic toggle);
    int n = 0;
    while ((expQ.size() != 0 || busy) && n < 100) begin
      nextCycle();
      if (toggle) res_ready = ~res_ready;
      n++;
    end
    checkVal(name, 32'(expQ.size()), 32'd0);
  endtask

  // One isolated request with cycle-exact latency checks; returns the tile seen at t+3.
  task automatic runSingle(input logic [1:0] op, input tile16_t a, input tile16_t b,
                           input logic [3:0] tag, output tile16_t got);
    logic f;
    nextCycle();
    setReq(1'b1, op, a, b, tag);
    @(negedge clk);
    checkVal("single_ready_t0", 32'(req_ready), 32'd1);
    checkTile("single_inA_t0", core_inA, a);
    checkTile("single_inB_t0", core_inB, b);
    checkVal("single_op_t0", 32'(core_op), 32'd0);
    sampleFire(f);
    nextCycle();
    setReq(1'b0, 2'd0, zeroT, zeroT, 4'd0);
    @(negedge clk);
    checkVal("single_op_t1", 32'(core_op), 32'(op));
    checkVal("single_valid_t1", 32'(res_valid), 32'd0);
    checkTile("single_inA_t1", core_inA, zeroT);
    nextCycle();
    @(negedge clk);
    checkVal("single_op_t2", 32'(core_op), 32'd0);
    checkVal("single_valid_t2", 32'(res_valid), 32'd0);
    nextCycle();
    @(negedge clk);
    checkVal("single_valid_t3", 32'(res_valid), 32'd1);
    checkVal("single_tag_t3", 32'(res_tag), 32'(tag));
    checkVal("single_resop_t3", 32'(res_op), 32'(op));
    got = res_data;
  endtask

  // Scoreboard monitor: every accepted result is compared in acceptance order.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && res_valid && res_ready) begin
      popCount++;
      outstanding--;
      if (expQ.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected: got tag %0d expected no result", res_tag);
      end else begin
        e = expQ.pop_front();
        checkVal("sb_tag", 32'(res_tag), 32'(e.tag));
        checkVal("sb_op", 32'(res_op), 32'(e.op));
        checkTile("sb_data", res_data, e.data);
      end
    end
  end

  always @(posedge clk) begin
    if (outstanding > maxOut) maxOut = outstanding;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    tile16_t tA;
    tile16_t tI;
    tile16_t got;
    logic    f;
    int      accepts;
    int      sent;
    int      cyc;
    int      popBase;
    int      sawValid;
    logic [1:0] ops [4];

    zeroT     = '0;
    rst       = 1'b1;
    res_ready = 1'b0;
    setReq(1'b0, 2'd0, zeroT, zeroT, 4'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkVal("rst_req_ready", 32'(req_ready), 32'd0);
    checkVal("rst_res_valid", 32'(res_valid), 32'd0);
    checkVal("rst_busy", 32'(busy), 32'd0);
    checkVal("rst_core_op", 32'(core_op), 32'd0);
    checkTile("rst_res_data", res_data, zeroT);
    checkVal("rst_res_tag", 32'(res_tag), 32'd0);
    checkVal("rst_res_op", 32'(res_op), 32'd0);
    nextCycle();
    rst = 1'b0;
    @(negedge clk);
    checkVal("idle_req_ready", 32'(req_ready), 32'd1);

    // MAC against identity returns A unchanged.
    res_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        tA[i][j] = 16'(i * 4 + j);
        tI[i][j] = (i == j) ? 16'd1 : 16'd0;
      end
    end
    runSingle(OP_MAC, tA, tI, 4'd3, got);
    checkTile("mac_identity", got, tA);
    drain("mac_drain", 1'b0);

    // L2 distance: row0 of A against row1 of B.
    tA = '0;
    tI = '0;
    tA[0][0] = 16'd1; tA[0][1] = 16'd2; tA[0][2] = 16'd3;
    tI[1][0] = 16'd4; tI[1][1] = 16'd6; tI[1][2] = 16'd8;
    runSingle(OP_L2D, tA, tI, 4'd5, got);
    checkVal("l2_elem01", 32'(got[0][1]), 32'd50);
    checkVal("l2_elem00", 32'(got[0][0]), 32'd14);
    checkVal("l2_elem11", 32'(got[1][1]), 32'd116);
    checkVal("l2_elem22", 32'(got[2][2]), 32'd0);
    drain("l2_drain", 1'b0);

    // Backpressure: four accepts then no credit until the first pop.
    res_ready = 1'b0;
    accepts = 0;
    for (int c = 0; c < 8; c++) begin
      nextCycle();
      setReq(1'b1, OP_MAC, mkTile(accepts), mkTile(accepts + 5), 4'(accepts));
      @(negedge clk);
      checkVal("bp_ready_pattern", 32'(req_ready), (c < 4) ? 32'd1 : 32'd0);
      sampleFire(f);
      if (f) accepts++;
    end
    checkVal("bp_accepts", 32'(accepts), 32'd4);
    nextCycle();
    setReq(1'b0, 2'd0, zeroT, zeroT, 4'd0);
    res_ready = 1'b1;
    @(negedge clk);
    checkVal("bp_valid_full", 32'(res_valid), 32'd1);
    checkVal("bp_ready_at_pop", 32'(req_ready), 32'd0);
    nextCycle();
    @(negedge clk);
    checkVal("bp_ready_after_pop", 32'(req_ready), 32'd1);
    drain("bp_drain", 1'b0);

    // Mixed back-to-back ops: core_op follows the op stream one cycle late.
    ops[0] = OP_MAC; ops[1] = OP_L2D; ops[2] = OP_MAC; ops[3] = OP_L2D;
    for (int k = 0; k < 6; k++) begin
      nextCycle();
      if (k < 4) setReq(1'b1, ops[k], mkTile(10 + k), mkTile(20 + k), 4'(8 + k));
      else       setReq(1'b0, 2'd0, zeroT, zeroT, 4'd0);
      @(negedge clk);
      if (k < 4) begin
        sampleFire(f);
        checkVal("b2b_fire", 32'(f), 32'd1);
      end
      if (k >= 1 && k <= 4) checkVal("b2b_core_op", 32'(core_op), 32'(ops[k-1]));
      if (k == 5) checkVal("b2b_core_op_idle", 32'(core_op), 32'd0);
    end
    drain("b2b_drain", 1'b0);

    // Reset with two requests in flight discards them.
    for (int k = 0; k < 2; k++) begin
      nextCycle();
      setReq(1'b1, OP_MAC, mkTile(50 + k), mkTile(60 + k), 4'(1 + k));
      @(negedge clk);
      sampleFire(f);
    end
    nextCycle();
    setReq(1'b0, 2'd0, zeroT, zeroT, 4'd0);
    rst = 1'b1;
    @(negedge clk);
    checkVal("mid_rst_ready", 32'(req_ready), 32'd0);
    checkVal("mid_rst_valid", 32'(res_valid), 32'd0);
    checkVal("mid_rst_busy", 32'(busy), 32'd0);
    checkVal("mid_rst_core_op", 32'(core_op), 32'd0);
    nextCycle();
    rst = 1'b0;
    expQ.delete();
    outstanding = 0;
    @(negedge clk);
    checkVal("post_rst_ready", 32'(req_ready), 32'd1);
    checkVal("post_rst_busy", 32'(busy), 32'd0);
    sawValid = 0;
    for (int k = 0; k < 4; k++) begin
      nextCycle();
      @(negedge clk);
      if (res_valid || busy) sawValid++;
    end
    checkVal("post_rst_quiet", 32'(sawValid), 32'd0);
    runSingle(OP_MAC, mkTile(70), mkTile(71), 4'd7, got);
    checkTile("post_rst_result", got, coreModel(OP_MAC, mkTile(70), mkTile(71)));
    drain("post_rst_drain", 1'b0);

    // Wrap-around: ten requests with res_ready toggling each cycle.
    maxOut  = 0;
    popBase = popCount;
    sent    = 0;
    cyc     = 0;
    while (sent < 10 && cyc < 200) begin
      nextCycle();
      res_ready = (cyc % 2) == 1;
      setReq(1'b1, (sent % 2 == 1) ? OP_L2D : OP_MAC, mkTile(30 + sent), mkTile(40 + sent),
             4'(sent));
      @(negedge clk);
      sampleFire(f);
      if (f) sent++;
      cyc++;
    end
    nextCycle();
    setReq(1'b0, 2'd0, zeroT, zeroT, 4'd0);
    drain("wrap_drain", 1'b1);
    checkVal("wrap_sent", 32'(sent), 32'd10);
    checkVal("wrap_popped", 32'(popCount - popBase), 32'd10);
    checkVal("wrap_max_outstanding_le4", 32'(maxOut <= 4), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
